hack_instr_composer: RTL and testbench

// Interactive Hack instruction encoder for Basys3: operator enters type, A-value or comp/dest/jump fields on sw[15:0], one field per debounced button press.

---
 rtl/hack_instr_composer.sv | 214 +++++++++++++++++++++
 tb/tb_hack_instr_composer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_instr_composer.sv
// Interactive Hack instruction encoder: debounced step/cancel buttons walk the operator through
// type, A-value or comp/dest/jump entry and offer the packed word on a valid/ready port.
// Optional build macro: HACK_COMP_CHECK_EN rejects comp fields that are not legal Hack comp codes.
module hack_instr_composer #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned ADDR_W          = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       sw,
   input  logic              btn_step,
   input  logic              btn_cancel,
   output logic [15:0]       instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [2:0]        state,
   output logic              err,
   output logic [15:0]       preview
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned NBTN  = 2;

   typedef enum logic [2:0] {
      S_TYPE = 3'd0,
      S_AVAL = 3'd1,
      S_COMP = 3'd2,
      S_DEST = 3'd3,
      S_JUMP = 3'd4,
      S_EMIT = 3'd5
   } stateT;

   // ---------------- button conditioning ----------------
   logic [NBTN-1:0] rawBtn;
   logic [NBTN-1:0] syncA;
   logic [NBTN-1:0] syncB;
   logic [NBTN-1:0] stableQ;
   logic [NBTN-1:0] pulseQ;
   logic [CNT_W-1:0] cntQ [NBTN];
   logic stepPulse;
   logic cancelPulse;

   assign rawBtn      = {btn_cancel, btn_step};
   assign stepPulse   = pulseQ[0];
   assign cancelPulse = pulseQ[1];

   // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         syncA   <= '0;
         syncB   <= '0;
         stableQ <= '0;
         pulseQ  <= '0;
         for (int i = 0; i < int'(NBTN); i++) cntQ[i] <= '0;
      end else begin
         syncA <= rawBtn;
         syncB <= syncA;
         for (int i = 0; i < int'(NBTN); i++) begin
            pulseQ[i] <= 1'b0;
            if (syncB[i] == stableQ[i]) begin
               cntQ[i] <= '0;
            end else if (cntQ[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               stableQ[i] <= syncB[i];
               pulseQ[i]  <= syncB[i];
               cntQ[i]    <= '0;
            end else begin
               cntQ[i] <= cntQ[i] + CNT_W'(1);
            end
         end
      end
   end

`ifdef HACK_COMP_CHECK_EN
   // The 28 {a,c} combinations defined by the Hack ALU.
   function automatic logic isLegalComp(input logic [6:0] ac);
      case (ac)
         7'b0101010, 7'b0111111, 7'b0111010, 7'b0001100, 7'b0110000,
         7'b0001101, 7'b0110001, 7'b0001111, 7'b0110011, 7'b0011111,
         7'b0110111, 7'b0001110, 7'b0110010, 7'b0000010, 7'b0010011,
         7'b0000111, 7'b0000000, 7'b0010101,
         7'b1110000, 7'b1110001, 7'b1110011, 7'b1110111, 7'b1110010,
         7'b1000010, 7'b1010011, 7'b1000111, 7'b1000000, 7'b1010101:
            isLegalComp = 1'b1;
         default:
            isLegalComp = 1'b0;
      endcase
   endfunction
`endif

   // ---------------- entry FSM ----------------
   stateT             stateQ, stateD;
   logic [15:0]       instrQ, instrD;
   logic              validQ, validD;
   logic [ADDR_W-1:0] addrQ, addrD;
   logic [15:0]       previewQ, previewD;
   logic              errQ, errD;
   logic [6:0]        compQ, compD;
   logic [2:0]        destQ, destD;
   logic              xfer;

   assign xfer = validQ & instr_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ   <= S_TYPE;
         instrQ   <= '0;
         validQ   <= 1'b0;
         addrQ    <= '0;
         previewQ <= '0;
         errQ     <= 1'b0;
         compQ    <= '0;
         destQ    <= '0;
      end else begin
         stateQ   <= stateD;
         instrQ   <= instrD;
         validQ   <= validD;
         addrQ    <= addrD;
         previewQ <= previewD;
         errQ     <= errD;
         compQ    <= compD;
         destQ    <= destD;
      end
   end

   always_comb begin
      stateD   = stateQ;
      instrD   = instrQ;
      validD   = validQ;
      addrD    = addrQ;
      previewD = previewQ;
      errD     = errQ;
      compD    = compQ;
      destD    = destQ;

      // A handshake on the same edge as a cancel still counts as a transfer.
      if (xfer) addrD = addrQ + ADDR_W'(1);

      if (cancelPulse) begin
         stateD   = S_TYPE;
         validD   = 1'b0;
         previewD = '0;
         errD     = 1'b0;
      end else begin
         case (stateQ)
            S_TYPE: begin
               if (stepPulse) begin
                  previewD = '0;
                  stateD   = sw[15] ? S_COMP : S_AVAL;
               end
            end
            S_AVAL: begin
               if (stepPulse) begin
                  instrD   = {1'b0, sw[14:0]};
                  previewD = {1'b0, sw[14:0]};
                  validD   = 1'b1;
                  stateD   = S_EMIT;
               end
            end
            S_COMP: begin
               if (stepPulse) begin
`ifdef HACK_COMP_CHECK_EN
                  if (!isLegalComp(sw[6:0])) begin
                     errD = 1'b1;
                  end else begin
                     errD     = 1'b0;
                     compD    = sw[6:0];
                     previewD = {3'b111, sw[6:0], 6'b000000};
                     stateD   = S_DEST;
                  end
`else
                  compD    = sw[6:0];
                  previewD = {3'b111, sw[6:0], 6'b000000};
                  stateD   = S_DEST;
`endif
               end
            end
            S_DEST: begin
               if (stepPulse) begin
                  destD    = sw[2:0];
                  previewD = {previewQ[15:6], sw[2:0], 3'b000};
                  stateD   = S_JUMP;
               end
            end
            S_JUMP: begin
               if (stepPulse) begin
                  instrD   = {3'b111, compQ, destQ, sw[2:0]};
                  previewD = {3'b111, compQ, destQ, sw[2:0]};
                  validD   = 1'b1;
                  stateD   = S_EMIT;
               end
            end
            S_EMIT: begin
               if (xfer) begin
                  validD = 1'b0;
                  stateD = S_TYPE;
               end
            end
            default: begin
               stateD = S_TYPE;
               validD = 1'b0;
            end
         endcase
      end
   end

   assign instr       = instrQ;
   assign instr_valid = validQ;
   assign wr_addr     = addrQ;
   assign state       = stateQ;
   assign err         = errQ;
   assign preview     = previewQ;

endmodule

// File: tb/tb_hack_instr_composer.sv
// Randomised bench for hack_instr_composer: a field-level model of the entry procedure is
// advanced once per completed button press and compared against the DUT every settled cycle.
module tb_hack_instr_composer;

   localparam int unsigned DEB   = 4;
   localparam int unsigned AW    = 2;
   localparam int          DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   sw;
   logic          btn_step;
   logic          btn_cancel;
   logic [15:0]   instr;
   logic          instr_valid;
   logic          instr_ready;
   logic [AW-1:0] wr_addr;
   logic [2:0]    state;
   logic          err;
   logic [15:0]   preview;

   hack_instr_composer #(.DEBOUNCE_CYCLES(DEB), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .sw(sw), .btn_step(btn_step), .btn_cancel(btn_cancel),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .wr_addr(wr_addr), .state(state), .err(err), .preview(preview)
   );

   always #5 clk = ~clk;

   int nCmp = 0;
   int nBad = 0;

   // Model: stage number, offered word, address counter, partial word.
   int          mStage;
   logic [15:0] mInstr;
   logic [15:0] mPreview;
   logic        mValid;
   logic        mErr;
   int          mAddr;
   logic [6:0]  mComp;
   logic [2:0]  mDest;
   bit          settled;

`ifdef HACK_COMP_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit legalComp(input logic [6:0] v);
      return v inside {7'h2A, 7'h3F, 7'h3A, 7'h0C, 7'h30, 7'h0D, 7'h31, 7'h0F, 7'h33,
                       7'h1F, 7'h37, 7'h0E, 7'h32, 7'h02, 7'h13, 7'h07, 7'h00, 7'h15,
                       7'h70, 7'h71, 7'h73, 7'h77, 7'h72, 7'h42, 7'h53, 7'h47, 7'h40, 7'h55};
   endfunction

   task automatic modelStep(input logic [15:0] s);
      case (mStage)
         0: begin mPreview = 16'h0; mStage = s[15] ? 2 : 1; end
         1: begin
            mInstr = s & 16'h7FFF; mPreview = mInstr; mValid = 1'b1; mStage = 5;
         end
         2: begin
            if (CHECK_EN && !legalComp(s[6:0])) mErr = 1'b1;
            else begin
               mErr = 1'b0; mComp = s[6:0];
               mPreview = 16'hE000 | (16'(s[6:0]) << 6); mStage = 3;
            end
         end
         3: begin mDest = s[2:0]; mPreview = mPreview | (16'(s[2:0]) << 3); mStage = 4; end
         4: begin
            mInstr = 16'hE000 | (16'(mComp) << 6) | (16'(mDest) << 3) | 16'(s[2:0]);
            mPreview = mInstr; mValid = 1'b1; mStage = 5;
         end
         default: ;
      endcase
   endtask

   task automatic modelCancel();
      mStage = 0; mValid = 1'b0; mPreview = 16'h0; mErr = 1'b0;
   endtask

   // Model-side reset and handshake, sampled on the same edge as the DUT.
   always @(posedge clk) begin
      if (rst) begin
         mStage = 0; mInstr = 16'h0; mPreview = 16'h0; mValid = 1'b0;
         mErr = 1'b0; mAddr = 0; mComp = 7'h0; mDest = 3'h0;
      end else if (mValid && instr_ready) begin
         mAddr = (mAddr + 1) % DEPTH;
         mValid = 1'b0;
         mStage = 0;
      end
   end

   always @(negedge clk) begin
      if (settled && !rst) begin
         check("state", 16'(state), 16'(mStage));
         check("instr_valid", 16'(instr_valid), 16'(mValid));
         check("wr_addr", 16'(wr_addr), 16'(mAddr));
         check("preview", preview, mPreview);
         check("err", 16'(err), 16'(mErr));
         if (mValid) check("instr", instr, mInstr);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Full debounced press: hold long enough to register, release long enough to settle.
   task automatic press(input bit doStep, input bit doCancel, input logic [15:0] s);
      instr_ready = 1'b0;
      settled = 1'b0;
      sw = s;
      btn_step = doStep;
      btn_cancel = doCancel;
      tick(8);
      btn_step = 1'b0;
      btn_cancel = 1'b0;
      tick(10);
      if (doCancel) modelCancel();
      else if (doStep) modelStep(s);
      settled = 1'b1;
   endtask

   task automatic glitch(input int len);
      settled = 1'b0;
      btn_step = 1'b1;
      tick(len);
      btn_step = 1'b0;
      tick(10);
      settled = 1'b1;
   endtask

   task automatic wiggle(input int n);
      for (int i = 0; i < n; i++) begin
         sw = 16'($urandom);
         tick(1);
      end
   endtask

   task automatic waitXfer();
      instr_ready = 1'b1;
      for (int i = 0; i < 20 && mValid; i++) tick(1);
      if (mValid) check("xfer_timeout", 16'd1, 16'd0);
      instr_ready = 1'b0;
      tick(1);
   endtask

   task automatic doReset();
      settled = 1'b0;
      btn_step = 1'b0;
      btn_cancel = 1'b0;
      instr_ready = 1'b0;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      settled = 1'b1;
   endtask

   initial begin
      settled = 1'b0;
      sw = 16'h0; btn_step = 1'b0; btn_cancel = 1'b0; instr_ready = 1'b0;
      doReset();
      check("rst_state", 16'(state), 16'd0);
      check("rst_valid", 16'(instr_valid), 16'd0);
      check("rst_addr", 16'(wr_addr), 16'd0);
      check("rst_preview", preview, 16'h0);

      // A-instruction @0
      press(1, 0, 16'h0000);
      press(1, 0, 16'h0015);
      check("a_instr", instr, 16'h0015);
      check("a_valid", 16'(instr_valid), 16'd1);
      check("a_addr", 16'(wr_addr), 16'd0);
      waitXfer();
      check("a_addr_next", 16'(wr_addr), 16'd1);

      // D=D+A @1
      press(1, 0, 16'h8000);
      press(1, 0, 16'h0002);
      press(1, 0, 16'h0002);
      press(1, 0, 16'h0000);
      check("ddpa_instr", instr, 16'hE090);
      waitXfer();

      // D;JGT @2 with ready held low and switches moving
      press(1, 0, 16'hFFFF);
      press(1, 0, 16'h000C);
      press(1, 0, 16'h0000);
      press(1, 0, 16'h0001);
      wiggle(5);
      check("jgt_instr", instr, 16'hE301);
      check("jgt_valid", 16'(instr_valid), 16'd1);
      waitXfer();
      check("addr_3", 16'(wr_addr), 16'd3);

      // fourth transfer wraps the address
      press(1, 0, 16'h0000);
      press(1, 0, 16'h7FFF);
      waitXfer();
      check("addr_wrap", 16'(wr_addr), 16'd0);

      // short bounces do not step
      glitch(1); glitch(2); glitch(3);
      check("glitch_state", 16'(state), 16'd0);

      // cancel after comp/dest entry
      press(1, 0, 16'h8000);
      press(1, 0, 16'h0030);
      press(1, 0, 16'h0005);
      press(0, 1, 16'h0000);
      check("cancel_state", 16'(state), 16'd0);
      check("cancel_preview", preview, 16'h0);
      check("cancel_addr", 16'(wr_addr), 16'd0);

      // cancel and step together
      press(1, 1, 16'h8000);
      check("both_state", 16'(state), 16'd0);

`ifdef HACK_COMP_CHECK_EN
      press(1, 0, 16'h8000);
      press(1, 0, 16'h007F);
      check("illegal_err", 16'(err), 16'd1);
      check("illegal_state", 16'(state), 16'd2);
      press(0, 1, 16'h0000);
`endif

      // randomised entries with cancels, bounces, resets and ready stalls
      for (int t = 0; t < 40; t++) begin
         int r;
         r = int'($urandom_range(0, 19));
         if (r == 0) doReset();
         else if (r == 1) glitch(int'($urandom_range(1, 3)));
         for (int k = 0; k < 12 && mStage != 5; k++) begin
            if ($urandom_range(0, 9) == 0) press(0, 1, 16'($urandom));
            else press(1, 0, 16'($urandom));
            if ($urandom_range(0, 3) == 0) wiggle(int'($urandom_range(1, 3)));
         end
         if (mStage == 5) begin
            wiggle(int'($urandom_range(0, 5)));
            if ($urandom_range(0, 7) == 0) begin
               press(1, 0, 16'($urandom));
            end
            waitXfer();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
